// File: rtl/count_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : count_pkg
//  Purpose  : Shared constants and the watcher state encoding for the
//             count_watch block.
//  Contents : CNT_W   - width of the upstream mod-16 counter value
//             CNT_MAX - last value before the counter wraps to zero
//             state_t - watcher FSM states (IDLE, ARMED, HIT)
//  Revision : 1.0 - initial release
// ============================================================================
package count_pkg;

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_t;

endpackage : count_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at its all-ones value instead of
//             rolling over. A clear wins over an increment in the same cycle.
//  Ports    : clk     - clock, rising edge
//             reset_n - asynchronous active-low reset
//             inc     - count up by one this cycle (ignored at saturation)
//             clr     - zero the counter next cycle (priority over inc)
//             value   - current count, straight from the register
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/count_watch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : count_watch
//  Purpose  : Monitors the sample stream of an upstream 4-bit mod-16
//             counter. Watches for an armed target value (hit handshake),
//             counts 15->0 wrap-arounds and flags out-of-sequence samples.
//  Ports    : clk       - clock, rising edge
//             reset_n   - asynchronous active-low reset
//             cnt_in    - counter sample
//             cnt_valid - cnt_in is a new sample this cycle
//             cnt_load  - upstream counter was loaded/zeroed for this sample
//             target    - match value, captured when arm is accepted
//             arm       - start watching for target (accepted only in IDLE)
//             ack       - acknowledge a pending hit
//             clr       - clear wraps and err_skip
//             hit       - target seen; held until ack
//             busy      - watcher is ARMED or HIT
//             wraps     - saturating count of 15->0 wraps
//             err_skip  - sticky: a sample was not predecessor+1 mod 16
//  Revision : 1.0 - initial release
// ============================================================================
module count_watch
    import count_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              cnt_valid,
    input  logic              cnt_load,
    input  logic [CNT_W-1:0]  target,
    input  logic              arm,
    input  logic              ack,
    input  logic              clr,
    output logic              hit,
    output logic              busy,
    output logic [WRAP_W-1:0] wraps,
    output logic              err_skip
);

    state_t           r_state;
    logic [CNT_W-1:0] r_tgt_q;
    logic [CNT_W-1:0] r_prev_q;
    logic             r_prev_v;

    logic             w_seq_chk;
    logic [CNT_W-1:0] w_prev_inc;
    logic             w_wrap;
    logic             w_skip;

    // Sequence checks only apply when there is a trusted predecessor and the
    // upstream counter was not just reloaded.
    assign w_seq_chk  = cnt_valid & r_prev_v & ~cnt_load;
    assign w_prev_inc = r_prev_q + CNT_W'(1);   // natural mod-16 wrap
    assign w_wrap     = w_seq_chk & (r_prev_q == CNT_MAX) & (cnt_in == '0);
    assign w_skip     = w_seq_chk & (cnt_in != w_prev_inc);

    // ------------------------------------------------------------------
    // Watcher FSM. hit/busy are registered alongside the state so they
    // always equal the decode of the state they accompany.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_tgt_q <= '0;
            hit     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A sample in the arm cycle is never compared: the
                    // comparison only happens from ARMED onward.
                    if (arm) begin
                        r_tgt_q <= target;
                        r_state <= ARMED;
                        busy    <= 1'b1;
                        hit     <= 1'b0;
                    end
                end
                ARMED: begin
                    if (cnt_valid && (cnt_in == r_tgt_q)) begin
                        r_state <= HIT;
                        hit     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                HIT: begin
                    // An arm arriving with ack is dropped, not queued.
                    if (ack) begin
                        r_state <= IDLE;
                        hit     <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    hit     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Predecessor tracking and sticky skip flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_q <= '0;
            r_prev_v <= 1'b0;
        end else if (cnt_valid) begin
            r_prev_q <= cnt_in;
            r_prev_v <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_skip <= 1'b0;
        end else if (clr) begin
            err_skip <= 1'b0;
        end else if (w_skip) begin
            err_skip <= 1'b1;
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_wrap),
        .clr     (clr),
        .value   (wraps)
    );

endmodule : count_watch
`default_nettype wire

// File: tb/tb_count_watch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_count_watch
//  Purpose  : Self-checking bench for count_watch. Two instances share all
//             inputs: one with the default 8-bit wrap counter and one with a
//             2-bit wrap counter to exercise saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_count_watch;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic       cnt_load;
    logic [3:0] target;
    logic       arm;
    logic       ack;
    logic       clr;

    logic       hit8, busy8, err8;
    logic [7:0] wraps8;
    logic       hit2, busy2, err2;
    logic [1:0] wraps2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    count_watch #(.WRAP_W(8)) dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .cnt_in    (cnt_in),
        .cnt_valid (cnt_valid),
        .cnt_load  (cnt_load),
        .target    (target),
        .arm       (arm),
        .ack       (ack),
        .clr       (clr),
        .hit       (hit8),
        .busy      (busy8),
        .wraps     (wraps8),
        .err_skip  (err8)
    );

    count_watch #(.WRAP_W(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .cnt_in    (cnt_in),
        .cnt_valid (cnt_valid),
        .cnt_load  (cnt_load),
        .target    (target),
        .arm       (arm),
        .ack       (ack),
        .clr       (clr),
        .hit       (hit2),
        .busy      (busy2),
        .wraps     (wraps2),
        .err_skip  (err2)
    );

    typedef struct {
        string      nm;
        logic       v;
        logic       ld;
        logic [3:0] c;
        logic       a;
        logic [3:0] t;
        logic       k;
        logic       cl;
        logic       eh;
        logic       eb;
        int         ew8;
        int         ew2;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic v, input logic ld,
                                input logic [3:0] c, input logic a, input logic [3:0] t,
                                input logic k, input logic cl, input logic eh,
                                input logic eb, input int ew8, input int ew2,
                                input logic ee);
        vec_t r;
        r.nm = nm; r.v = v; r.ld = ld; r.c = c; r.a = a; r.t = t; r.k = k;
        r.cl = cl; r.eh = eh; r.eb = eb; r.ew8 = ew8; r.ew2 = ew2; r.ee = ee;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_outs(input string nm, input logic eh, input logic eb,
                              input int ew8, input int ew2, input logic ee);
        chk({nm, ".hit"},    int'(hit8),   int'(eh));
        chk({nm, ".busy"},   int'(busy8),  int'(eb));
        chk({nm, ".wraps8"}, int'(wraps8), ew8);
        chk({nm, ".wraps2"}, int'(wraps2), ew2);
        chk({nm, ".err"},    int'(err8),   int'(ee));
        chk({nm, ".hit2"},   int'(hit2),   int'(eh));
        chk({nm, ".busy2"},  int'(busy2),  int'(eb));
        chk({nm, ".err2"},   int'(err2),   int'(ee));
    endtask

    task automatic apply(input vec_t r);
        cnt_valid = r.v; cnt_load = r.ld; cnt_in = r.c;
        arm = r.a; target = r.t; ack = r.k; clr = r.cl;
        @(posedge clk);
        #1;
        check_outs(r.nm, r.eh, r.eb, r.ew8, r.ew2, r.ee);
    endtask

    task automatic step(input string nm, input logic v, input logic ld,
                        input logic [3:0] c, input logic a, input logic [3:0] t,
                        input logic k, input logic cl, input logic eh,
                        input logic eb, input int ew8, input int ew2,
                        input logic ee);
        apply(mk(nm, v, ld, c, a, t, k, cl, eh, eb, ew8, ew2, ee));
    endtask

    initial begin
        reset_n = 1'b0; cnt_in = '0; cnt_valid = 1'b0; cnt_load = 1'b0;
        target = '0; arm = 1'b0; ack = 1'b0; clr = 1'b0;
        #1;
        check_outs("rst", 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Main table: arm on 5, count 0..7, hold hit without ack, then
        // wrap/skip traffic while still in HIT (match logic independent).
        tbl.push_back(mk("arm5", 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0));
        for (int s = 0; s < 8; s++)
            tbl.push_back(mk($sformatf("s%0d", s), 1'b1, 1'b0, 4'(s), 1'b0, 4'd0, 1'b0, 1'b0,
                             (s >= 5), 1'b1, 0, 0, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk($sformatf("hold%0d", i), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0,
                             1'b1, 1'b1, 0, 0, 1'b0));
        tbl.push_back(mk("w14l", 1'b1, 1'b1, 4'd14, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0));
        tbl.push_back(mk("w15",  1'b1, 1'b0, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0));
        tbl.push_back(mk("w0",   1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0));
        tbl.push_back(mk("w1",   1'b1, 1'b0, 4'd1,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0));
        tbl.push_back(mk("k3l",  1'b1, 1'b1, 4'd3,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0));
        tbl.push_back(mk("k9l",  1'b1, 1'b1, 4'd9,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0));
        tbl.push_back(mk("k3l2", 1'b1, 1'b1, 4'd3,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0));
        tbl.push_back(mk("k9",   1'b1, 1'b0, 4'd9,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1));
        tbl.push_back(mk("clr",  1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0));
        foreach (tbl[i]) apply(tbl[i]);

        // ack with a concurrent arm: back to IDLE only
        step("ackarm",  1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step("idle",    1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // ARMED ignores ack and a re-arm (target stays 9)
        step("arm9",    1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("ackarmd", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("rearm8",  1'b1, 1'b1, 4'd8, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("s9hit",   1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        step("armhit",  1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        step("ack9",    1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Sample in the arm cycle is not compared
        step("arm4s4",  1'b1, 1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("nocmp",   1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("s4hit",   1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        step("ack4",    1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // One sample producing both a match and a wrap
        step("arm0",    1'b0, 1'b0, 4'd0,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("s15l",    1'b1, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step("s0mw",    1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0);
        step("ack0",    1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        step("clr2",    1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        // Five wraps: 8-bit counter reaches 5, 2-bit counter sticks at 3
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("sat%0d_15", i), 1'b1, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, i - 1, (i - 1 > 3) ? 3 : i - 1, 1'b0);
            step($sformatf("sat%0d_0", i), 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, i, (i > 3) ? 3 : i, 1'b0);
        end
        // clr beats a wrap, then beats a skip
        step("satw15",  1'b1, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3, 1'b0);
        step("clrwrap", 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        step("clrskip", 1'b1, 1'b0, 4'd7,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        step("skip9",   1'b1, 1'b0, 4'd9,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        step("clr3",    1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        // Reset in the middle of ARMED with a nonzero wrap count
        step("r15l",    1'b1, 1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step("r0",      1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        step("arm11",   1'b0, 1'b0, 4'd0,  1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0);
        arm = 1'b0;
        reset_n = 1'b0;
        #1;
        check_outs("rstarmd", 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("rsthold", 1'b0, 1'b0, 0, 0, 1'b0);
        reset_n = 1'b1;
        step("first0",  1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step("next1",   1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step("s11",     1'b1, 1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_count_watch
`default_nettype wire

// File: doc/count_watch.md
COUNT_WATCH -- requirements
Module: count_watch

Interface
REQ-001 Parameter WRAP_W, default 8: width of the saturating wrap counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cnt_in  input  4  count value from the upstream 4-bit mod-16 counter.
REQ-005 cnt_valid  input  1  cnt_in is a new sample this cycle.
REQ-006 cnt_load  input  1  upstream counter was loaded or zeroed for this sample; qualifies cnt_valid.
REQ-007 target  input  4  match value; sampled only when arm is accepted.
REQ-008 arm  input  1  single-cycle request to start watching for target.
REQ-009 ack  input  1  acknowledge of hit.
REQ-010 clr  input  1  clear wraps and err_skip.
REQ-011 hit  output  1  registered level; target matched, held until acknowledged.
REQ-012 busy  output  1  high in ARMED or HIT.
REQ-013 wraps  output  WRAP_W  saturating count of 15->0 wrap-arounds.
REQ-014 err_skip  output  1  sticky flag; sample was not predecessor+1 mod 16.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ARMED and HIT.
REQ-016 IDLE: arm SHALL latch target into tgt_q and move to ARMED next cycle; otherwise stay in IDLE.
REQ-017 ARMED: cnt_valid with cnt_in==tgt_q SHALL move to HIT; arm and ack SHALL be ignored.
REQ-018 HIT: ack SHALL move to IDLE; arm SHALL be ignored.
REQ-019 hit SHALL be 1 exactly while in HIT, rising one cycle after the matching sample.
REQ-020 busy SHALL be 1 in ARMED and HIT and 0 in IDLE.
REQ-021 A sample that arrives in the same cycle arm is accepted SHALL NOT be compared.
REQ-022 ack and a new arm in the same HIT cycle SHALL return to IDLE only; arm is dropped.
REQ-023 The block SHALL keep prev_q (4 bits) and prev_v; every cnt_valid cycle SHALL load prev_q<=cnt_in and set prev_v<=1.
REQ-024 A wrap SHALL be cnt_valid & prev_v & !cnt_load & prev_q==15 & cnt_in==0; each wrap increments wraps by 1.
REQ-025 wraps SHALL saturate at 2^WRAP_W-1 and never roll over.
REQ-026 A skip SHALL be cnt_valid & prev_v & !cnt_load & cnt_in != (prev_q+1) mod 16; a skip sets err_skip.
REQ-027 A sample with cnt_load=1 SHALL update prev_q but SHALL NOT produce a wrap or a skip.
REQ-028 The first valid sample after reset (prev_v=0) SHALL NOT produce a wrap or a skip.
REQ-029 clr SHALL zero wraps and err_skip next cycle and take priority over a wrap or skip in the same cycle.
REQ-030 clr SHALL NOT affect the FSM, prev_q or prev_v.
REQ-031 Match logic SHALL be independent of wrap and skip logic; one sample may cause a match, a wrap and a skip together.

Reset
REQ-032 reset_n low SHALL immediately force state=IDLE, tgt_q=0, prev_q=0, prev_v=0, wraps=0 and err_skip=0.
REQ-033 During reset hit and busy SHALL be 0.
REQ-034 Reset asserted mid-ARMED or mid-HIT SHALL abandon the operation; no ack is required afterwards.

Structure
REQ-035 Package count_pkg SHALL hold CNT_W=4, CNT_MAX=15 and the state enum {IDLE, ARMED, HIT}.
REQ-036 The saturating wrap counter SHALL be a sub-module, sat_counter (parameter W; inc, clr, value), with clr priority.
REQ-037 All outputs SHALL be driven directly from flops.

Verification
REQ-038 Reset, arm with target=5, then samples 0..7 valid each cycle: hit rises the cycle after sample 5, busy=1 from the cycle after arm.
REQ-039 Hold ack=0 for 10 cycles: hit stays 1; pulse ack: hit=0 and busy=0 next cycle; an arm in the ack cycle is ignored.
REQ-040 Samples 14,15,0,1 with cnt_load=0: wraps 0->1, err_skip=0.
REQ-041 Samples 3,9 gives err_skip=1; samples 3 then 9 with cnt_load=1 gives err_skip=0.
REQ-042 WRAP_W=2, five wraps: wraps holds 3; clr in the same cycle as a wrap gives wraps=0.
REQ-043 reset_n low while ARMED: busy=0 and wraps=0 immediately; the next first sample 0 gives no wrap and no skip.
